// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch->decode instruction queue.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH       = 8;
    localparam int unsigned FQ_FETCH_WIDTH = 2;
    localparam int unsigned FQ_ISSUE_WIDTH = 2;
    localparam int unsigned FQ_PTR_W       = $clog2(FQ_DEPTH);

    typedef logic [31:0] virt_t;
    typedef logic [31:0] uint32_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] code;
    } exception_t;

    typedef struct packed {
        virt_t      pc;
        uint32_t    inst;
        exception_t ex;
        logic       pred_taken;
        virt_t      pred_target;
    } fq_entry_t;

    // Number of set bits in a lane-valid vector (up to four lanes).
    function automatic int unsigned lane_count(input logic [3:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage: FETCH_WIDTH write ports, ISSUE_WIDTH asynchronous read ports.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = FQ_DEPTH,
    parameter int unsigned FETCH_WIDTH = FQ_FETCH_WIDTH,
    parameter int unsigned ISSUE_WIDTH = FQ_ISSUE_WIDTH,
    parameter int unsigned PTR_W       = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic      [FETCH_WIDTH-1:0]             wr_en_i,
    input  logic      [FETCH_WIDTH-1:0][PTR_W-1:0]  wr_addr_i,
    input  fq_entry_t [FETCH_WIDTH-1:0]             wr_data_i,
    input  logic      [ISSUE_WIDTH-1:0][PTR_W-1:0]  rd_addr_i,
    output fq_entry_t [ISSUE_WIDTH-1:0]             rd_data_o
);

    fq_entry_t mem_q [DEPTH];

    // Write lanes always target distinct slots, so no port priority is needed.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            if (wr_en_i[k]) begin
                mem_q[wr_addr_i[k]] <= wr_data_i[k];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            rd_data_o[i] = mem_q[rd_addr_i[i]];
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Multi-lane fetch->decode instruction queue: pointers, count, allowin, flush.
// Optional zero-latency pass-through when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = FQ_DEPTH,
    parameter int unsigned FETCH_WIDTH = FQ_FETCH_WIDTH,
    parameter int unsigned ISSUE_WIDTH = FQ_ISSUE_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic      [FETCH_WIDTH-1:0]       in_valid,
    input  fq_entry_t [FETCH_WIDTH-1:0]       in_entry,
    output logic                              fs_allowin,
    output logic      [ISSUE_WIDTH-1:0]       out_valid,
    output fq_entry_t [ISSUE_WIDTH-1:0]       out_entry,
    input  logic                              ds_allowin,
    output logic      [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        bypass;
    int unsigned n_in, n_avail, n_byp, n_pop, n_wr;

    logic      [FETCH_WIDTH-1:0]            wr_en;
    logic      [FETCH_WIDTH-1:0][PTR_W-1:0] wr_addr;
    fq_entry_t [FETCH_WIDTH-1:0]            wr_data;
    logic      [ISSUE_WIDTH-1:0][PTR_W-1:0] rd_addr;
    fq_entry_t [ISSUE_WIDTH-1:0]            rd_data;

    // Space check uses only the registered count: no decode->fetch comb path.
    assign fs_allowin = !reset && (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign occupancy  = count_q;

    always_comb begin
        n_in    = fs_allowin ? lane_count(4'(in_valid)) : 0;
        n_avail = (32'(count_q) < ISSUE_WIDTH) ? 32'(count_q) : ISSUE_WIDTH;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass  = (count_q == '0) && !flush && ds_allowin;
`else
        bypass  = 1'b0;
`endif
        n_byp   = bypass ? ((n_in < ISSUE_WIDTH) ? n_in : ISSUE_WIDTH) : 0;
        n_pop   = (ds_allowin && !flush) ? n_avail : 0;
        n_wr    = n_in - n_byp;

        head_d  = head_q + PTR_W'(n_pop);
        tail_d  = tail_q + PTR_W'(n_wr);
        count_d = count_q + CNT_W'(n_wr) - CNT_W'(n_pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Lanes already consumed by the bypass are skipped; the rest pack from tail.
    always_comb begin
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            wr_en[k]   = !flush && (k < n_wr);
            wr_addr[k] = tail_q + PTR_W'(k);
            wr_data[k] = '0;
            for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
                if (j == k + n_byp) begin
                    wr_data[k] = in_entry[j];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            rd_addr[i]   = head_q + PTR_W'(i);
            out_valid[i] = (i < n_avail);
            out_entry[i] = (i < n_avail) ? rd_data[i] : '0;
            if (bypass) begin
                out_valid[i] = (i < n_byp);
                out_entry[i] = '0;
                for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
                    if ((j == i) && (i < n_byp)) begin
                        out_entry[i] = in_entry[j];
                    end
                end
            end
            if (flush || reset) begin
                out_valid[i] = 1'b0;
                out_entry[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH       (DEPTH),
        .FETCH_WIDTH (FETCH_WIDTH),
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .PTR_W       (PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q <= CNT_W'(DEPTH));
    a_contig_valid: assert property (@(posedge clk) disable iff (reset)
        (in_valid & (in_valid + FETCH_WIDTH'(1))) == '0);
    a_push_allowed: assert property (@(posedge clk) disable iff (reset)
        (n_in != 0) |-> fs_allowin);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, wrap sequence, random vs queue model.
`timescale 1ns/1ps
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned FW    = 2;
    localparam int unsigned IW    = 2;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] B = 32'hbfc0_0000;

    logic clk = 1'b0;
    logic reset, flush, ds_allowin, fs_allowin;
    logic      [FW-1:0]    in_valid;
    fq_entry_t [FW-1:0]    in_entry;
    logic      [IW-1:0]    out_valid;
    fq_entry_t [IW-1:0]    out_entry;
    logic      [OCC_W-1:0] occupancy;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_entry   (in_entry),
        .fs_allowin (fs_allowin),
        .out_valid  (out_valid),
        .out_entry  (out_entry),
        .ds_allowin (ds_allowin),
        .occupancy  (occupancy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    fq_entry_t   mq[$];
    logic        m_allow;
    int unsigned m_nin, m_byp;
    bit          track_en = 1'b0;
    logic [31:0] exp_ret;

    typedef struct {
        logic        rst;
        logic        fl;
        logic [1:0]  v;
        logic        ds;
        logic [31:0] base;
        logic        ex_allow;
        logic [1:0]  ex_valid;
        int unsigned ex_occ;
        logic [31:0] ex_pc0;
        logic [31:0] ex_pc1;
    } vec_t;
    vec_t tbl[19];

    function automatic fq_entry_t mk(input logic [31:0] pc);
        fq_entry_t e;
        e.pc          = pc;
        e.inst        = ~pc;
        e.ex          = 6'(pc >> 2);
        e.pred_taken  = pc[3];
        e.pred_target = pc + 32'd8;
        return e;
    endfunction

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic [FW-1:0] v,
                         input logic ds, input logic [31:0] base);
        reset      = rst;
        flush      = fl;
        in_valid   = v;
        ds_allowin = ds;
        for (int i = 0; i < FW; i++) in_entry[i] = mk(base + 32'(4 * i));
    endtask

    // Queue-level expectation for the current cycle's outputs.
    task automatic model_check(input string tag);
        int unsigned sz;
        logic [IW-1:0] ev;
        fq_entry_t [IW-1:0] ee;
        sz      = mq.size();
        m_allow = !reset && ((DEPTH - sz) >= FW);
        m_nin   = m_allow ? $countones(in_valid) : 0;
        m_byp   = 0;
        ev      = '0;
        for (int i = 0; i < IW; i++) ee[i] = '0;
        if (!reset && !flush) begin
            if (BYP && sz == 0 && ds_allowin) begin
                m_byp = umin(m_nin, IW);
                for (int i = 0; i < int'(m_byp); i++) begin
                    ev[i] = 1'b1;
                    ee[i] = in_entry[i];
                end
            end else begin
                for (int i = 0; i < int'(umin(sz, IW)); i++) begin
                    ev[i] = 1'b1;
                    ee[i] = mq[i];
                end
            end
        end
        check({tag, " allowin"}, 128'(fs_allowin), 128'(m_allow));
        check({tag, " out_valid"}, 128'(out_valid), 128'(ev));
        check({tag, " occupancy"}, 128'(occupancy), 128'(sz));
        for (int i = 0; i < IW; i++)
            check($sformatf("%s entry%0d", tag, i), 128'(out_entry[i]), 128'(ee[i]));
    endtask

    task automatic model_update();
        if (reset || flush) begin
            mq.delete();
        end else begin
            int unsigned np;
            np = ds_allowin ? umin(mq.size(), IW) : 0;
            repeat (np) void'(mq.pop_front());
            for (int i = int'(m_byp); i < int'(m_nin); i++) mq.push_back(in_entry[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input logic rst, input logic fl, input logic [FW-1:0] v,
                        input logic ds, input logic [31:0] base, input string tag);
        drive(rst, fl, v, ds, base);
        #2;
        model_check(tag);
        if (track_en && ds && !rst && !fl) begin
            for (int i = 0; i < IW; i++) begin
                if (out_valid[i]) begin
                    check($sformatf("%s retire_pc", tag), 128'(out_entry[i].pc), 128'(exp_ret));
                    exp_ret += 32'd4;
                end
            end
        end
        tick();
    endtask

    initial begin
        logic [31:0] push_pc;
        logic [31:0] rpc;

        tbl[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0,   1'b0, 2'b00, 0, 32'h0,  32'h0};
        tbl[1]  = '{1'b0, 1'b0, 2'b11, 1'b0, B,       1'b1, 2'b00, 0, 32'h0,  32'h0};
        tbl[2]  = '{1'b0, 1'b0, 2'b11, 1'b0, B+8,     1'b1, 2'b11, 2, B,      B+4};
        tbl[3]  = '{1'b0, 1'b0, 2'b11, 1'b0, B+'h10,  1'b1, 2'b11, 4, B,      B+4};
        tbl[4]  = '{1'b0, 1'b0, 2'b11, 1'b0, B+'h18,  1'b1, 2'b11, 6, B,      B+4};
        tbl[5]  = '{1'b0, 1'b0, 2'b11, 1'b0, B+'h20,  1'b0, 2'b11, 8, B,      B+4};
        tbl[6]  = '{1'b0, 1'b0, 2'b11, 1'b1, B+'h20,  1'b0, 2'b11, 8, B,      B+4};
        tbl[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 2'b11, 6, B+8,    B+'hc};
        tbl[8]  = '{1'b0, 1'b1, 2'b11, 1'b1, B+'h30,  1'b1, 2'b00, 6, 32'h0,  32'h0};
        tbl[9]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 2'b00, 0, 32'h0,  32'h0};
        if (BYP) begin
            tbl[10] = '{1'b0, 1'b0, 2'b11, 1'b1, B+'h40, 1'b1, 2'b11, 0, B+'h40, B+'h44};
            tbl[11] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0,  1'b1, 2'b00, 0, 32'h0,  32'h0};
            tbl[12] = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h0,  1'b1, 2'b00, 0, 32'h0,  32'h0};
        end else begin
            tbl[10] = '{1'b0, 1'b0, 2'b11, 1'b1, B+'h40, 1'b1, 2'b00, 0, 32'h0,  32'h0};
            tbl[11] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0,  1'b1, 2'b11, 2, B+'h40, B+'h44};
            tbl[12] = '{1'b0, 1'b0, 2'b00, 1'b1, 32'h0,  1'b1, 2'b11, 2, B+'h40, B+'h44};
        end
        tbl[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 2'b00, 0, 32'h0,  32'h0};
        tbl[14] = '{1'b0, 1'b0, 2'b11, 1'b0, B+'h50,  1'b1, 2'b00, 0, 32'h0,  32'h0};
        tbl[15] = '{1'b0, 1'b0, 2'b11, 1'b0, B+'h58,  1'b1, 2'b11, 2, B+'h50, B+'h54};
        tbl[16] = '{1'b0, 1'b0, 2'b01, 1'b0, B+'h60,  1'b1, 2'b11, 4, B+'h50, B+'h54};
        tbl[17] = '{1'b1, 1'b0, 2'b11, 1'b1, B+'h70,  1'b0, 2'b00, 5, 32'h0,  32'h0};
        tbl[18] = '{1'b0, 1'b0, 2'b00, 1'b0, 32'h0,   1'b1, 2'b00, 0, 32'h0,  32'h0};

        drive(1'b1, 1'b0, '0, 1'b0, 32'h0);
        @(posedge clk);
        #1;

        // Directed vectors: fill to full, pop at full, flush, empty push, reset mid-run.
        for (int r = 0; r < 19; r++) begin
            drive(tbl[r].rst, tbl[r].fl, tbl[r].v, tbl[r].ds, tbl[r].base);
            #2;
            model_check($sformatf("row%0d", r));
            check($sformatf("row%0d vec_allowin", r), 128'(fs_allowin), 128'(tbl[r].ex_allow));
            check($sformatf("row%0d vec_valid", r), 128'(out_valid), 128'(tbl[r].ex_valid));
            check($sformatf("row%0d vec_occ", r), 128'(occupancy), 128'(tbl[r].ex_occ));
            if (tbl[r].ex_valid[0])
                check($sformatf("row%0d vec_pc0", r), 128'(out_entry[0].pc), 128'(tbl[r].ex_pc0));
            if (tbl[r].ex_valid[1])
                check($sformatf("row%0d vec_pc1", r), 128'(out_entry[1].pc), 128'(tbl[r].ex_pc1));
            tick();
        end

        // Single-lane pushes around the pointer wrap; retire order must match push order.
        push_pc  = 32'h8000_0000;
        exp_ret  = push_pc;
        track_en = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step(1'b0, 1'b0, 2'b01, 1'b0, push_pc, $sformatf("wrapfill%0d", c));
            push_pc += 32'(4 * m_nin);
        end
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 1'b0, 2'b01, 1'b1, push_pc, $sformatf("wrap%0d", c));
            push_pc += 32'(4 * m_nin);
        end
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 2'b00, 1'b1, 32'h0, $sformatf("drain%0d", c));
        check("wrap all_retired", 128'(exp_ret), 128'(push_pc));
        track_en = 1'b0;

        // Random traffic against the queue model.
        rpc = 32'h1000_0000;
        for (int c = 0; c < 600; c++) begin
            int unsigned n;
            logic [FW-1:0] v;
            logic rst_r, fl_r, ds_r;
            n     = $urandom_range(FW, 0);
            v     = FW'((1 << n) - 1);
            rst_r = ($urandom_range(63, 0) == 0);
            fl_r  = ($urandom_range(15, 0) == 0);
            ds_r  = ($urandom_range(2, 0) != 0);
            step(rst_r, fl_r, v, ds_r, rpc, $sformatf("rnd%0d", c));
            rpc += 32'(4 * FW);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
